// File: rtl/mseq_sync_rx_if.sv
// Link bundle between the M-sequence bit source and the receive synchroniser.
// The master side drives the bit stream; the slave side reports lock, phase and errors.
interface mseq_sync_rx_if #(
    parameter int WIDTH = 4
);
    logic             sclk;
    logic             signal;
    logic             lock;
    logic [WIDTH-1:0] phase;
    logic             frame;
    logic             err_pulse;
    logic [15:0]      err_cnt;
    logic [7:0]       pos;

    modport master (
        output sclk, signal,
        input  lock, phase, frame, err_pulse, err_cnt, pos
    );

    modport slave (
        input  sclk, signal,
        output lock, phase, frame, err_pulse, err_cnt, pos
    );
endinterface

// File: rtl/mseq_sync_rx.sv
// Self-synchronising M-sequence receiver: fills a local LFSR window from the line,
// acquires on consecutive correct predictions, then flywheels and reports errors and frames.
module mseq_sync_rx #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] TYPE_PARAM = 4'b1101,
    parameter logic [WIDTH-1:0] SEED_PARAM = 4'b0101,
    parameter int               LOCK_CNT   = 8,
    parameter int               UNLOCK_ERR = 3
) (
    input  logic          CLK_50MHZ,
    input  logic          rst_n,
    mseq_sync_rx_if.slave bus
);
    localparam int FCW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_FILL, S_ACQ, S_LOCK} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_window, w_window_nxt;
    logic [FCW-1:0]   r_fill_cnt, w_fill_nxt;
    logic [7:0]       r_match_cnt, w_match_nxt;
    logic [7:0]       r_err_run, w_err_run_nxt;
    logic             r_lock, w_lock_nxt;
    logic             r_frame, w_frame_nxt;
    logic             r_err_pulse, w_err_pulse_nxt;
    logic [15:0]      r_err_cnt, w_err_cnt_nxt;
    logic [7:0]       r_pos, w_pos_nxt;

    logic             w_pred;
    logic             w_bad;
    logic [WIDTH-1:0] w_shift_sig;
    logic [WIDTH-1:0] w_shift_pred;
    logic [7:0]       w_match_inc;
    logic [7:0]       w_err_run_inc;

    // Window bit 0 is the oldest bit; new bits enter at the top.
    assign w_pred        = ^(r_window & TYPE_PARAM);
    assign w_shift_sig   = {bus.signal, r_window[WIDTH-1:1]};
    assign w_shift_pred  = {w_pred, r_window[WIDTH-1:1]};
    assign w_bad         = (bus.signal != w_pred) || (r_window == '0);
    assign w_match_inc   = r_match_cnt + 8'd1;
    assign w_err_run_inc = r_err_run + 8'd1;

    // NOTE: every next-state variable gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        w_state_nxt     = r_state;
        w_window_nxt    = r_window;
        w_fill_nxt      = r_fill_cnt;
        w_match_nxt     = r_match_cnt;
        w_err_run_nxt   = r_err_run;
        w_lock_nxt      = r_lock;
        w_frame_nxt     = 1'b0;
        w_err_pulse_nxt = 1'b0;
        w_err_cnt_nxt   = r_err_cnt;
        w_pos_nxt       = r_pos;

        if (bus.sclk) begin
            unique case (r_state)
                S_FILL: begin
                    w_window_nxt = w_shift_sig;
                    w_fill_nxt   = r_fill_cnt + FCW'(1);
                    if (r_fill_cnt == FCW'(WIDTH - 1)) begin
                        w_state_nxt = S_ACQ;
                        w_match_nxt = 8'd0;
                    end
                end
                S_ACQ: begin
                    w_window_nxt = w_shift_sig;
                    w_match_nxt  = w_bad ? 8'd0 : w_match_inc;
                    if (!w_bad && w_match_inc == 8'(LOCK_CNT)) begin
                        w_state_nxt   = S_LOCK;
                        w_err_run_nxt = 8'd0;
                        w_pos_nxt     = 8'd0;
                        w_lock_nxt    = 1'b1;
                    end
                end
                S_LOCK: begin
                    // Flywheel on the prediction so a single line error costs exactly one error.
                    w_window_nxt  = w_shift_pred;
                    w_err_run_nxt = 8'd0;
                    if (w_bad) begin
                        w_err_pulse_nxt = 1'b1;
                        w_err_run_nxt   = w_err_run_inc;
                        if (r_err_cnt != 16'hFFFF) w_err_cnt_nxt = r_err_cnt + 16'd1;
                    end
                    if (w_bad && w_err_run_inc == 8'(UNLOCK_ERR)) begin
                        w_state_nxt   = S_FILL;
                        w_fill_nxt    = '0;
                        w_match_nxt   = 8'd0;
                        w_err_run_nxt = 8'd0;
                        w_lock_nxt    = 1'b0;
                        w_pos_nxt     = 8'd0;
                    end else if (w_shift_pred == SEED_PARAM) begin
                        w_frame_nxt = 1'b1;
                        w_pos_nxt   = 8'd0;
                    end else if (r_pos != 8'hFF) begin
                        w_pos_nxt = r_pos + 8'd1;
                    end
                end
                default: w_state_nxt = S_FILL;
            endcase
        end
    end

    // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge CLK_50MHZ) begin
        if (!rst_n) begin
            r_state     <= S_FILL;
            r_window    <= '0;
            r_fill_cnt  <= '0;
            r_match_cnt <= 8'd0;
            r_err_run   <= 8'd0;
            r_lock      <= 1'b0;
            r_frame     <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= 16'd0;
            r_pos       <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_window    <= w_window_nxt;
            r_fill_cnt  <= w_fill_nxt;
            r_match_cnt <= w_match_nxt;
            r_err_run   <= w_err_run_nxt;
            r_lock      <= w_lock_nxt;
            r_frame     <= w_frame_nxt;
            r_err_pulse <= w_err_pulse_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_pos       <= w_pos_nxt;
        end
    end

    assign bus.lock      = r_lock;
    assign bus.phase     = r_window;
    assign bus.frame     = r_frame;
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.pos       = r_pos;
endmodule

// File: tb/tb_mseq_sync_rx.sv
// Scoreboard bench for mseq_sync_rx: a behavioural receiver model pushes expected outputs
// per strobe, and they are popped and compared one cycle after the strobe edge.
module tb_mseq_sync_rx;
    logic clk;
    logic rst_n;

    mseq_sync_rx_if #(.WIDTH(4)) bus ();

    mseq_sync_rx dut (
        .CLK_50MHZ (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic        lock;
        logic [3:0]  phase;
        logic        frame;
        logic        err_pulse;
        logic [15:0] err_cnt;
        logic [7:0]  pos;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state (0=FILL, 1=ACQ, 2=LOCK)
    int          m_state;
    logic [3:0]  m_win;
    int          m_fill, m_match, m_err_run;
    logic        m_lock;
    logic [15:0] m_err_cnt;
    logic [7:0]  m_pos;

    logic obs_frame;
    logic saw_lock, saw_frame;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Generator stream from seed 0101: 1,0,1,0,0,0,1 repeating.
    function automatic logic gen(input int k);
        logic [6:0] pat;
        pat = 7'b1000101;
        return pat[k % 7];
    endfunction

    task automatic model_reset();
        m_state = 0; m_win = 4'd0; m_fill = 0; m_match = 0; m_err_run = 0;
        m_lock = 1'b0; m_err_cnt = 16'd0; m_pos = 8'd0;
    endtask

    task automatic model_step(input logic s, output exp_t e);
        logic p, bad;
        e.frame = 1'b0;
        e.err_pulse = 1'b0;
        p = ^(m_win & 4'b1101);
        bad = (s != p) || (m_win == 4'd0);
        case (m_state)
            0: begin
                m_win = {s, m_win[3:1]};
                m_fill++;
                if (m_fill == 4) begin m_state = 1; m_match = 0; end
            end
            1: begin
                m_match = bad ? 0 : m_match + 1;
                m_win = {s, m_win[3:1]};
                if (m_match == 8) begin
                    m_state = 2; m_err_run = 0; m_pos = 8'd0; m_lock = 1'b1;
                end
            end
            default: begin
                m_win = {p, m_win[3:1]};
                if (bad) begin
                    e.err_pulse = 1'b1;
                    if (m_err_cnt != 16'hFFFF) m_err_cnt++;
                    m_err_run++;
                end else begin
                    m_err_run = 0;
                end
                if (m_err_run == 3) begin
                    m_state = 0; m_fill = 0; m_match = 0; m_err_run = 0;
                    m_lock = 1'b0; m_pos = 8'd0;
                end else if (m_win == 4'b0101) begin
                    e.frame = 1'b1; m_pos = 8'd0;
                end else if (m_pos != 8'hFF) begin
                    m_pos++;
                end
            end
        endcase
        e.lock = m_lock; e.phase = m_win; e.err_cnt = m_err_cnt; e.pos = m_pos;
    endtask

    task automatic compare_pop();
        exp_t e;
        check("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("lock",      32'(bus.lock),      32'(e.lock));
            check("phase",     32'(bus.phase),     32'(e.phase));
            check("frame",     32'(bus.frame),     32'(e.frame));
            check("err_pulse", 32'(bus.err_pulse), 32'(e.err_pulse));
            check("err_cnt",   32'(bus.err_cnt),   32'(e.err_cnt));
            check("pos",       32'(bus.pos),       32'(e.pos));
        end
    endtask

    // One strobe followed by three idle clocks; called and returning at posedge+1.
    task automatic strobe(input logic s);
        exp_t e;
        logic [3:0] ph;
        bus.sclk = 1'b1;
        bus.signal = s;
        model_step(s, e);
        sb.push_back(e);
        @(posedge clk); #1;
        bus.sclk = 1'b0;
        bus.signal = 1'b0;
        obs_frame = bus.frame;
        saw_lock  = saw_lock | bus.lock;
        saw_frame = saw_frame | bus.frame;
        compare_pop();
        ph = bus.phase;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_frame", 32'(bus.frame), 32'd0);
            check("idle_err",   32'(bus.err_pulse), 32'd0);
            check("idle_phase", 32'(bus.phase), 32'(ph));
        end
    endtask

    // Reset for one cycle, optionally with a strobe in the same cycle.
    task automatic reset_pulse(input logic s_clk, input logic s);
        exp_t e;
        rst_n = 1'b0;
        bus.sclk = s_clk;
        bus.signal = s;
        model_reset();
        e.lock = 1'b0; e.phase = 4'd0; e.frame = 1'b0; e.err_pulse = 1'b0;
        e.err_cnt = 16'd0; e.pos = 8'd0;
        sb.push_back(e);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.sclk = 1'b0;
        bus.signal = 1'b0;
        compare_pop();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.sclk = 1'b0;
        bus.signal = 1'b0;
        saw_lock = 1'b0;
        saw_frame = 1'b0;
        obs_frame = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_pulse(1'b0, 1'b0);

        // Acquisition: b0..b11
        for (int k = 0; k <= 11; k++) begin
            strobe(gen(k));
            if (k == 10) check("acq_not_yet_locked", 32'(bus.lock), 32'd0);
        end
        check("lock_after_b11",  32'(bus.lock),    32'd1);
        check("phase_after_b11", 32'(bus.phase),   32'h2);
        check("errcnt_at_lock",  32'(bus.err_cnt), 32'd0);

        // Frame timing with a single inverted bit at b20
        for (int k = 12; k <= 24; k++) begin
            strobe(k == 20 ? ~gen(k) : gen(k));
            if (k == 17 || k == 24) begin
                check("frame_on_time", 32'(obs_frame), 32'd1);
                check("frame_phase",   32'(bus.phase), 32'h5);
                check("frame_pos",     32'(bus.pos),   32'd0);
            end
            if (k == 23) check("pos_before_frame", 32'(bus.pos), 32'd6);
            if (k == 20) check("single_err_cnt", 32'(bus.err_cnt), 32'd1);
        end
        check("lock_after_single_err", 32'(bus.lock),    32'd1);
        check("errcnt_after_b24",      32'(bus.err_cnt), 32'd1);

        // Loss of lock: b25..b27 inverted
        for (int k = 25; k <= 27; k++) begin
            strobe(~gen(k));
            if (k < 27) check("lock_held_during_errs", 32'(bus.lock), 32'd1);
        end
        check("lock_dropped",      32'(bus.lock),    32'd0);
        check("errcnt_after_loss", 32'(bus.err_cnt), 32'd4);

        // Resync: 4 fill + 8 acquire
        for (int k = 28; k <= 39; k++) begin
            strobe(gen(k));
            if (k == 38) check("relock_not_early", 32'(bus.lock), 32'd0);
        end
        check("relock",           32'(bus.lock),    32'd1);
        check("errcnt_kept",      32'(bus.err_cnt), 32'd4);

        // Reset mid-lock with a simultaneous strobe
        reset_pulse(1'b1, gen(40));
        check("rst_lock",   32'(bus.lock),    32'd0);
        check("rst_phase",  32'(bus.phase),   32'd0);
        check("rst_errcnt", 32'(bus.err_cnt), 32'd0);
        check("rst_pos",    32'(bus.pos),     32'd0);
        // Bit ignored: a fresh fill of b0..b3 yields the seed window
        for (int k = 0; k <= 3; k++) strobe(gen(k));
        check("refill_phase", 32'(bus.phase), 32'h5);

        // Dead line: 50 zero strobes from reset
        reset_pulse(1'b0, 1'b0);
        saw_lock = 1'b0;
        saw_frame = 1'b0;
        for (int k = 0; k < 50; k++) strobe(1'b0);
        check("dead_never_lock",  32'(saw_lock),    32'd0);
        check("dead_never_frame", 32'(saw_frame),   32'd0);
        check("dead_errcnt",      32'(bus.err_cnt), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mseq_sync_rx.md
Name: mseq_sync_rx

Overview:
- Receive-side counterpart of the M-function sequence generator.
- Takes the serial M-sequence bit stream and its per-bit strobe, self-synchronises a local LFSR to it, and declares lock.
- Once locked, the local LFSR flywheels. It flags bit errors, counts them, reports the recovered generator state and emits a frame pulse each time the sequence passes the seed phase.
- Sits on the far end of the out_fun/sclk link, in parallel with or ahead of the decoder.

Parameters:
- WIDTH, 4: LFSR length in bits.
- TYPE_PARAM, 4'b1101: feedback tap mask. fb = XOR of (window AND TYPE_PARAM).
- SEED_PARAM, 4'b0101: generator start phase, used for frame detection.
- LOCK_CNT, 8: consecutive correct predictions in ACQ needed to enter LOCK (1..255).
- UNLOCK_ERR, 3: consecutive mispredictions in LOCK that force resync (1..255).

Ports:
- CLK_50MHZ, input, 1: system clock; all logic on the rising edge.
- rst_n, input, 1: synchronous active-low reset.
- sclk, input, 1: bit strobe, one CLK_50MHZ cycle per bit. Every cycle it is high counts as one bit.
- signal, input, 1: serial sequence bit, valid when sclk=1.
- lock, output, 1: high while in LOCK.
- phase, output, WIDTH: current window, equal to the recovered generator state.
- frame, output, 1: one-cycle pulse when phase becomes SEED_PARAM while locked.
- err_pulse, output, 1: one-cycle pulse per mispredicted bit in LOCK.
- err_cnt, output, 16: total LOCK mispredictions, saturating at 16'hFFFF.
- pos, output, 8: bit index since last frame, saturating at 8'hFF.

Behaviour:
- Bit ordering and recurrence:
  - window[i] holds bit b(k+i), so bit0 is the oldest.
  - Shift rule: window <= {newbit, window[WIDTH-1:1]}.
  - Predicted next bit: pred = ^(window & TYPE_PARAM).
- Reset (rst_n=0 at a clock edge), with priority over sclk:
  - state=FILL; window, fill_cnt, match_cnt and err_run = 0.
  - All outputs 0, err_cnt=0.
- All state and outputs are registered. Every response appears on the cycle after the strobe edge. With sclk=0, nothing changes and the pulses are 0.
- FILL:
  - Each strobe: shift signal in, fill_cnt+1.
  - On the WIDTH-th bit: go to ACQ and clear match_cnt.
- ACQ:
  - Each strobe: compute pred from the pre-shift window.
  - If signal==pred and window!=0: match_cnt+1. Otherwise match_cnt=0.
  - Always shift signal in.
  - When match_cnt reaches LOCK_CNT: go to LOCK, clear err_run and pos, raise lock.
  - An all-zero window never counts as a match, so a dead or stuck-0 line never locks.
- LOCK (flywheel):
  - Each strobe: shift pred in, not signal. A single line error therefore costs exactly one error.
  - If signal!=pred or window==0:
    - err_pulse=1, err_cnt+1 (saturating), err_run+1.
    - When err_run reaches UNLOCK_ERR: go to FILL, clear fill_cnt/match_cnt/err_run, drop lock. Window contents are don't-care and are overwritten by refill.
  - On a match: err_run=0.
- frame/pos (LOCK only):
  - If the post-shift window==SEED_PARAM: frame=1 and pos=0.
  - Otherwise pos+1, saturating.
  - In FILL/ACQ: frame=0 and pos holds 0.
- Simultaneous events:
  - On the unlocking strobe, err_pulse still fires and err_cnt still increments.
  - frame is not raised on the unlocking strobe.
- err_cnt is cleared only by reset. It is not cleared by loss of lock.

Test Plan:
Default parameters; generator stream from seed 0101 is b0.. = 1,0,1,0,0,0,1,1,0,1,0,0,0,1,1,0,..., period 7 from b0.
- Acquisition:
  - Stimulus: reset, then strobe b0..b11, one strobe every 4 clocks.
  - Response: state is FILL through b3 and ACQ from b4. lock=1 the cycle after b11's strobe; phase=4'b0010; err_cnt=0.
- Frame timing:
  - Stimulus: continue with b12..b24.
  - Response: frame pulses after b17 and after b24, each with phase=4'b0101 and pos=0. pos=6 just before the b24 pulse.
- Single error:
  - Stimulus: once locked, invert b20 only.
  - Response: one err_pulse, err_cnt=1, lock stays 1, no further errors. The frame after b24 is still on time.
- Loss of lock:
  - Stimulus: invert three consecutive bits.
  - Response: err_cnt +3, lock=0 the cycle after the third. Resumes and reaches lock=1 again after 4+8 clean bits.
- Dead line:
  - Stimulus: 50 strobes with signal=0 from reset.
  - Response: lock never asserts, err_cnt=0, frame never pulses.
- Reset mid-lock:
  - Stimulus: assert rst_n=0 for 1 cycle while locked, with sclk=1 in the same cycle.
  - Response: next cycle lock, phase, err_cnt and pos are 0, state=FILL, and the strobed bit is ignored.
